// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command/response controller for the shared ALU, with shift-add multiply
module alu_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_cin,
  output logic [2:0]            alu_op,
  output logic                  alu_alue,
  input  logic [DATA_WIDTH-1:0] alu_r,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [DATA_WIDTH-1:0] rsp_hi,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_ADC = 4'b1001;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  state_t                state, state_nx;
  logic [3:0]            op_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] p_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  carry_q;

  logic [DATA_WIDTH-1:0] mul_p_nx;
  logic [DATA_WIDTH-1:0] mul_q_nx;
  logic                  mul_last;
  logic                  exec_sets_carry;

  function automatic logic op_valid(input logic [3:0] op);
    return (!op[3] && op != 4'b0111) || op == OP_MUL || op == OP_ADC;
  endfunction

  // MUL: {P,Q} shifts right one place per add; Q's vacated top bit takes the sum's LSB.
  assign mul_p_nx        = {alu_cout, alu_r[DATA_WIDTH-1:1]};
  assign mul_q_nx        = {alu_r[0], b_q[DATA_WIDTH-1:1]};
  assign mul_last        = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
  assign exec_sets_carry = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);

  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_op    = '0;
    alu_cin   = 1'b0;
    alu_alue  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (!op_valid(cmd_op))    state_nx = S_RESP;
          else if (cmd_op == OP_MUL) state_nx = S_MUL;
          else                       state_nx = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_alue = 1'b1;
        alu_a    = a_q;
        alu_b    = b_q;
        if (op_q == OP_ADC) begin
          alu_op  = 3'b000;
          alu_cin = carry_q;
        end else begin
          alu_op  = op_q[2:0];
        end
        state_nx = S_RESP;
      end
      S_MUL: begin
        alu_alue = 1'b1;
        alu_a    = p_q;
        alu_b    = b_q[0] ? a_q : '0;
        if (mul_last) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      rsp_data  <= '0;
      rsp_hi    <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            a_q   <= cmd_a;
            b_q   <= cmd_b;
            p_q   <= '0;
            cnt_q <= '0;
            if (!op_valid(cmd_op)) begin
              rsp_data  <= '0;
              rsp_hi    <= '0;
              rsp_zero  <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_carry <= carry_q;
            end
          end
        end
        S_EXEC: begin
          rsp_data <= alu_r;
          rsp_hi   <= '0;
          rsp_zero <= (alu_r == '0);
          rsp_err  <= 1'b0;
          if (exec_sets_carry) begin
            carry_q   <= alu_cout;
            rsp_carry <= alu_cout;
          end else begin
            rsp_carry <= carry_q;
          end
        end
        S_MUL: begin
          p_q   <= mul_p_nx;
          b_q   <= mul_q_nx;
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (mul_last) begin
            rsp_hi    <= mul_p_nx;
            rsp_data  <= mul_q_nx;
            rsp_zero  <= (mul_p_nx == '0) && (mul_q_nx == '0);
            rsp_err   <= 1'b0;
            rsp_carry <= carry_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - random and directed bench for alu_sequencer against a behavioural model
module tb_alu_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [3:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic [W-1:0] alu_a, alu_b, alu_r;
  logic         alu_cin, alu_alue, alu_cout;
  logic [2:0]   alu_op;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data, rsp_hi;
  logic         rsp_carry, rsp_zero, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rdy_mode = 0;

  bit m_pending = 0;
  bit m_carry   = 0;
  bit m_cin     = 0;
  int m_op, m_a, m_b, m_t, m_rsp_at;
  int e_data, e_hi;
  bit e_carry, e_zero, e_err;

  logic [W-1:0] r_d, r_h;
  logic         r_c, r_z, r_e;
  int           r_lat, r_alue;

  alu_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_alue(alu_alue),
    .alu_r(alu_r), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_hi(rsp_hi),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Shared ALU; floats to a junk pattern when not enabled.
  logic [W:0]   alu_t;
  logic [W-1:0] alu_neg;
  always_comb begin
    alu_neg = ~alu_a + {{(W-1){1'b0}}, 1'b1};
    alu_t   = {1'b1, 8'hA5};
    if (alu_alue) begin
      case (alu_op)
        3'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
        3'd1:    alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        3'd2:    alu_t = {1'b0, alu_a & alu_b};
        3'd3:    alu_t = {1'b0, alu_a | alu_b};
        3'd4:    alu_t = {1'b0, alu_neg};
        3'd5:    alu_t = {alu_a, 1'b0};
        3'd6:    alu_t = {alu_a[0], 1'b0, alu_a[W-1:1]};
        default: alu_t = '0;
      endcase
    end
    alu_r    = alu_t[W-1:0];
    alu_cout = alu_t[W];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: response computed from the operation's arithmetic at acceptance.
  always @(posedge clk) begin
    int s, mask, lat;
    cyc  = cyc + 1;
    mask = (1 << W) - 1;
    if (rst) begin
      m_pending = 0;
      m_carry   = 0;
    end else if (m_pending) begin
      if (cyc >= m_rsp_at && rsp_ready) m_pending = 0;
    end else if (cmd_valid) begin
      m_op  = int'(cmd_op);
      m_a   = int'(cmd_a);
      m_b   = int'(cmd_b);
      m_cin = m_carry;
      e_hi  = 0;
      e_err = 0;
      lat   = 2;
      case (m_op)
        0: begin s = m_a + m_b; e_data = s & mask; m_carry = (s > mask); end
        1: begin e_data = (m_a - m_b) & mask; m_carry = (m_a < m_b); end
        2: e_data = m_a & m_b;
        3: e_data = m_a | m_b;
        4: e_data = (256 - m_a) & mask;
        5: e_data = (m_a * 2) & mask;
        6: e_data = m_a / 2;
        8: begin s = m_a * m_b; e_data = s & mask; e_hi = s >> W; lat = W + 1; end
        9: begin s = m_a + m_b + int'(m_carry); e_data = s & mask; m_carry = (s > mask); end
        default: begin e_data = 0; e_err = 1; lat = 1; end
      endcase
      e_carry   = m_carry;
      e_zero    = (e_data == 0) && (e_hi == 0);
      m_t       = cyc;
      m_rsp_at  = cyc + lat;
      m_pending = 1;
    end
  end

  always @(negedge clk) begin
    bit exp_valid, exp_alue;
    int i;
    if (cyc > 0) begin
      exp_valid = m_pending && (cyc + 1 >= m_rsp_at);
      exp_alue  = m_pending && !e_err && (cyc <= m_rsp_at - 2);
      check("cmd_ready", 32'(cmd_ready), 32'(!m_pending));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      check("alu_alue", 32'(alu_alue), 32'(exp_alue));
      if (exp_valid) begin
        check("rsp_data", 32'(rsp_data), e_data);
        check("rsp_hi", 32'(rsp_hi), e_hi);
        check("rsp_carry", 32'(rsp_carry), 32'(e_carry));
        check("rsp_zero", 32'(rsp_zero), 32'(e_zero));
        check("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      if (!exp_alue) begin
        check("alu_bus_idle", 32'({alu_a, alu_b, alu_op, alu_cin}), 0);
      end else if (m_op == 8) begin
        i = cyc - m_t;
        check("mul_alu_a", 32'(alu_a), (m_a * (m_b & ((1 << i) - 1))) >> i);
        check("mul_alu_b", 32'(alu_b), ((m_b >> i) & 1) != 0 ? m_a : 0);
        check("mul_alu_ctl", 32'({alu_op, alu_cin}), 0);
      end else begin
        check("exec_alu_a", 32'(alu_a), m_a);
        check("exec_alu_b", 32'(alu_b), m_b);
        check("exec_alu_op", 32'(alu_op), (m_op == 9) ? 0 : (m_op & 7));
        check("exec_alu_cin", 32'(alu_cin), (m_op == 9) ? 32'(m_cin) : 0);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0)      rsp_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 1) rsp_ready = 1'b0;
    else                    rsp_ready = 1'b1;
  end

  task automatic wait_idle();
    int k = 0;
    while (m_pending && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (m_pending) check("idle_timeout", 1, 0);
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold,
                         output logic [W-1:0] d, output logic [W-1:0] h,
                         output logic c, output logic z, output logic e,
                         output int lat, output int alue_n);
    wait_idle();
    if (hold > 0) rdy_mode = 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_a     = W'($urandom);
    cmd_b     = W'($urandom);
    cmd_op    = 4'($urandom);
    lat = 0; alue_n = 0; d = '0; h = '0; c = 1'b0; z = 1'b0; e = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (alu_alue) alue_n++;
      if (rsp_valid) begin
        lat = i; d = rsp_data; h = rsp_hi; c = rsp_carry; z = rsp_zero; e = rsp_err;
        break;
      end
    end
    if (lat == 0) check("rsp_timeout", 0, 1);
    if (hold > 0) begin
      for (int j = 1; j < hold; j++) begin
        @(negedge clk);
        check("hold_stable", 32'({rsp_valid, rsp_data, rsp_hi, rsp_carry, rsp_zero, rsp_err}),
              32'({1'b1, d, h, c, z, e}));
        check("hold_cmd_ready", 32'(cmd_ready), 0);
        check("hold_alue", 32'(alu_alue), 0);
      end
      rdy_mode  = 2;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("release_cmd_ready", 32'(cmd_ready), 1);
      check("release_rsp_valid", 32'(rsp_valid), 0);
      rdy_mode = 0;
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    @(negedge clk);
    check("reset_rsp", 32'({rsp_valid, rsp_data, rsp_hi, rsp_carry, rsp_zero, rsp_err}), 0);
    check("reset_cmd_ready", 32'(cmd_ready), 1);
    check("reset_alu_bus", 32'({alu_alue, alu_a, alu_b, alu_op, alu_cin}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    run_cmd(4'h0, 8'hF0, 8'h20, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("add_data", 32'(r_d), 32'h10);
    check("add_carry", 32'(r_c), 1);
    check("add_zero", 32'(r_z), 0);
    check("add_latency", r_lat, 2);
    run_cmd(4'h9, 8'h01, 8'h01, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("adc_data", 32'(r_d), 32'h03);
    check("adc_carry", 32'(r_c), 0);

    run_cmd(4'h8, 8'hFF, 8'hFF, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("mul_ff_hi", 32'(r_h), 32'hFE);
    check("mul_ff_lo", 32'(r_d), 32'h01);
    check("mul_alue_cycles", r_alue, 8);
    check("mul_latency", r_lat, 9);
    run_cmd(4'h8, 8'h00, 8'h37, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("mul_zero", 32'({r_h, r_d, r_z}), 32'h00001);

    run_cmd(4'h1, 8'h05, 8'h07, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("sub_data", 32'(r_d), 32'hFE);
    check("sub_carry", 32'(r_c), 1);
    run_cmd(4'h6, 8'h81, 8'h00, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("shr_data", 32'(r_d), 32'h40);
    check("shr_carry_kept", 32'(r_c), 1);

    run_cmd(4'h7, 8'h12, 8'h34, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("inv_err", 32'(r_e), 1);
    check("inv_data", 32'({r_h, r_d}), 0);
    check("inv_zero", 32'(r_z), 1);
    check("inv_latency", r_lat, 1);
    check("inv_alue", r_alue, 0);
    check("inv_carry_kept", 32'(r_c), 1);

    run_cmd(4'h0, 8'h03, 8'h04, 3, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("hold_add_data", 32'(r_d), 32'h07);

    run_cmd(4'h1, 8'h05, 8'h07, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = 4'h8; cmd_a = 8'h5A; cmd_b = 8'hC3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mul_cmd_ready", 32'(cmd_ready), 1);
    check("rst_mul_alue", 32'(alu_alue), 0);
    check("rst_mul_rsp_valid", 32'(rsp_valid), 0);
    run_cmd(4'h9, 8'h10, 8'h20, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("rst_carry_cleared", 32'(r_d), 32'h30);
    run_cmd(4'h0, 8'h01, 8'h02, 0, r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    check("post_rst_add", 32'(r_d), 32'h03);

    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_cmd(4'($urandom_range(0, 15)), W'($urandom), W'($urandom), 0,
              r_d, r_h, r_c, r_z, r_e, r_lat, r_alue);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
